ram_burst: RTL and testbench
============================

# ram_burst

Parametrised successor to the team's 128-bit load / byte-read RAM register bank. Holds a DEPTH×DATA_W word store loaded in one cycle from a wide parallel bus. Supports single-word registered reads plus a new auto-incrementing burst-read mode with valid/ready backpressure, wrap-around addressing, completion/error flags and synchronous reset. Sits between the detection datapath (wide writer) and narrow byte-stream consumers.

## Interface
- DATA_W, 8, word width in bits
- DEPTH, 16, number of words in the store (≥2)
- ADDR_W, 8, width of addr and len (must satisfy 2^ADDR_W > DEPTH)

- clk  in  1  sole clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- rw  in  2  command: 0 Lock, 1 Read, 2 Write, 3 Burst
- addr  in  ADDR_W  word address for Read; start address for Burst
- len  in  ADDR_W  beat count for Burst (sampled with command)
- wdata  in  DATA_W*DEPTH  parallel load data; word i = wdata[DATA_W*i +: DATA_W]
- rdata  out  DATA_W  read/burst data, registered
- rvalid  out  1  rdata holds a valid word
- rready  in  1  consumer accepts the beat (burst mode only)
- busy  out  1  burst in progress; commands ignored
- done  out  1  one-cycle pulse at burst end
- err  out  1  one-cycle pulse, coincident with done, on rejected burst

## Operation
- States: IDLE, BURST, FIN.
- Reset: store all zero, rdata=0, rvalid=0, busy=0, done=0, err=0, state IDLE. Reset wins over any command in the same cycle and aborts a burst immediately, with no done pulse.
- IDLE, rw=Lock: store and rdata hold; rvalid=0.
- IDLE, rw=Write: store <= wdata; rdata holds; rvalid=0.
- IDLE, rw=Read: rdata <= word[addr] if addr<DEPTH, else 0; rvalid=1 for exactly one cycle, independent of rready.
- IDLE, rw=Burst: if addr≥DEPTH, go to FIN with err=1 and emit no beats. If len=0, go to FIN with err=0 and emit no beats. Otherwise ptr<=addr, remaining<=len, rdata<=word[addr], rvalid<=1, busy<=1, go to BURST.
- BURST: a beat transfers when rvalid&&rready. On transfer, ptr <= (ptr+1==DEPTH)?0:ptr+1 and remaining decrements. If remaining was 1, set rvalid<=0 and go to FIN; otherwise rdata<=word[next ptr]. Without a transfer, rdata/rvalid hold.
- len may exceed DEPTH; the pointer keeps wrapping, so the burst repeats words.
- FIN: done=1 (err as set), busy=0, rvalid=0; next cycle IDLE. done and err are low in every other state.
- rw is ignored in BURST and FIN. A Write during a burst is dropped, so the store stays stable for the whole burst.
- ptr arithmetic is modulo DEPTH and must not rely on power-of-two DEPTH.

## Timing
- Read: command at edge T → rdata/rvalid valid after edge T, during cycle T+1 (1-cycle latency).
- Write: store updated at edge T; a Read issued at T+1 returns the new data.
- Burst: command at edge T → first beat valid in cycle T+1. With rready held high, one beat per cycle. The last beat is accepted at edge T+len; done is high in cycle T+len+1; IDLE follows from T+len+2, and a new command is accepted at that edge.
- Rejected or len=0 burst: done (and err if rejected) in cycle T+1; busy never asserts.
- busy is high exactly while state=BURST.

## Test plan
- Reset, then Write wdata with byte i = i (DEPTH=16); Read addr 5 → rdata=0x05 with a 1-cycle rvalid pulse; Read addr 20 → rdata=0x00 with rvalid=1.
- Burst addr=14 len=4, rready=1 → beats 0x0E, 0x0F, 0x00, 0x01 on consecutive cycles; done one cycle after the last beat; busy high for 4 cycles.
- Burst addr=0 len=3 with rready toggling 1,0,0,1,1 → rdata holds during stalls; beats 0x00, 0x01, 0x02 in order, no duplicates or drops.
- Burst addr=16 → done=1 and err=1 in the same single cycle; rvalid never asserts. Burst len=0 → done=1, err=0.
- During a burst, issue Write with all-0xFF data → later beats still return the old words; a Read after done returns the old data.
- Assert rst mid-burst → next cycle rvalid=0, busy=0, done=0; a Read of any address returns 0x00.

Source files
------------

// File: rtl/ram_burst.sv
// ram_burst: DEPTH x DATA_W word store with wide parallel load,
// single-word registered reads and a wrapping burst-read port.
module ram_burst #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              rw,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [ADDR_W-1:0]       len,
    input  logic [DATA_W*DEPTH-1:0] wdata,
    output logic [DATA_W-1:0]       rdata,
    output logic                    rvalid,
    input  logic                    rready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] RW_LOCK  = 2'd0;
    localparam logic [1:0] RW_READ  = 2'd1;
    localparam logic [1:0] RW_WRITE = 2'd2;
    localparam logic [1:0] RW_BURST = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PW-1:0]       ptr, ptr_d, ptr_nxt;
    logic [ADDR_W-1:0]   rem, rem_d;
    logic [DATA_W-1:0]   rdata_d;
    logic                rvalid_d;
    logic                err_q, err_d;
    logic                mem_we;
    logic                addr_ok;

    assign addr_ok = (addr < ADDR_W'(DEPTH));

    // wrap explicitly so non-power-of-two depths stay in range
    assign ptr_nxt = (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);

    assign busy = (state == BURST);
    assign done = (state == FIN);
    assign err  = (state == FIN) && err_q;

    // next-state and datapath decode
    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        rem_d    = rem;
        rdata_d  = rdata;
        rvalid_d = 1'b0;
        err_d    = err_q;
        mem_we   = 1'b0;
        unique case (state)
            IDLE: begin
                err_d = 1'b0;
                unique case (rw)
                    RW_LOCK: begin
                    end
                    RW_WRITE: begin
                        mem_we = 1'b1;
                    end
                    RW_READ: begin
                        rdata_d  = addr_ok ? mem[addr[PW-1:0]] : '0;
                        rvalid_d = 1'b1;
                    end
                    RW_BURST: begin
                        if (!addr_ok) begin
                            state_d = FIN;
                            err_d   = 1'b1;
                        end else if (len == '0) begin
                            state_d = FIN;
                        end else begin
                            ptr_d    = addr[PW-1:0];
                            rem_d    = len;
                            rdata_d  = mem[addr[PW-1:0]];
                            rvalid_d = 1'b1;
                            state_d  = BURST;
                        end
                    end
                endcase
            end
            BURST: begin
                rvalid_d = rvalid;
                if (rvalid && rready) begin
                    ptr_d = ptr_nxt;
                    rem_d = rem - ADDR_W'(1);
                    if (rem == ADDR_W'(1)) begin
                        rvalid_d = 1'b0;
                        state_d  = FIN;
                    end else begin
                        rdata_d = mem[ptr_nxt];
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state register; reset aborts any burst without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // read-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr    <= '0;
            rem    <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ptr    <= ptr_d;
            rem    <= rem_d;
            rdata  <= rdata_d;
            rvalid <= rvalid_d;
            err_q  <= err_d;
        end
    end

    // word store, loaded whole from the wide bus
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (mem_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= wdata[DATA_W*i +: DATA_W];
            end
        end
    end

endmodule

// File: tb/tb_ram_burst.sv
// tb_ram_burst: scenario tasks for ram_burst with a
// queue scoreboard for burst beats.
module tb_ram_burst;

    localparam int DW = 8;
    localparam int DP = 16;
    localparam int AW = 8;

    logic           clk;
    logic           rst;
    logic [1:0]     rw;
    logic [AW-1:0]  addr;
    logic [AW-1:0]  len;
    logic [DW*DP-1:0] wdata;
    logic [DW-1:0]  rdata;
    logic           rvalid;
    logic           rready;
    logic           busy;
    logic           done;
    logic           err;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mdl [DP];
    logic [DW-1:0] exp_q [$];

    ram_burst #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rw(rw), .addr(addr), .len(len),
        .wdata(wdata), .rdata(rdata), .rvalid(rvalid),
        .rready(rready), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rw = 2'd0;
        addr = '0;
        len = '0;
        wdata = '0;
        rready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < DP; i++) mdl[i] = '0;
        checks++;
        if (rdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_rdata got %h want 00", rdata);
        end
        checks++;
        if ({rvalid, busy, done, err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got %b want 0000",
                     {rvalid, busy, done, err});
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < DP; i++) begin
            wdata[DW*i +: DW] = DW'(i);
            mdl[i] = DW'(i);
        end
        rw = 2'd2;
        tick();
        checks++;
        if (rvalid !== 1'b0) begin
            errors++;
            $display("FAIL write_rvalid got %b want 0", rvalid);
        end
        rw = 2'd1;
        addr = 8'd5;
        tick();
        checks++;
        if (rdata !== 8'h05 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL read5 got %h/%b want 05/1", rdata, rvalid);
        end
        rw = 2'd0;
        tick();
        checks++;
        if (rvalid !== 1'b0 || rdata !== 8'h05) begin
            errors++;
            $display("FAIL read5_pulse got %h/%b want 05/0",
                     rdata, rvalid);
        end
        rw = 2'd1;
        addr = 8'd20;
        tick();
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL read20 got %h/%b want 00/1", rdata, rvalid);
        end
        rw = 2'd0;
        tick();
    endtask

    // issues a burst, pushes expected beats, then drains them
    task automatic run_burst(
        input string         name,
        input logic [AW-1:0] a,
        input logic [AW-1:0] l,
        input logic [15:0]   pat,
        input int            wr_at,
        input int            exp_done,
        input int            exp_busy,
        input logic          exp_err
    );
        int n;
        int busy_n;
        int done_n;
        int rv_n;
        logic err_s;
        logic stalled;
        logic [DW-1:0] held;
        logic [DW-1:0] want;
        int p;
        exp_q.delete();
        if (a < AW'(DP)) begin
            p = int'(a);
            for (int k = 0; k < int'(l); k++) begin
                exp_q.push_back(mdl[p]);
                p = (p + 1) % DP;
            end
        end
        rw = 2'd3;
        addr = a;
        len = l;
        tick();
        rw = 2'd0;
        n = 1;
        busy_n = 0;
        done_n = -1;
        rv_n = 0;
        err_s = 1'b0;
        stalled = 1'b0;
        held = '0;
        while (done_n < 0 && n < 64) begin
            rready = (n - 1 < 16) ? pat[n-1] : 1'b1;
            if (n == wr_at) begin
                rw = 2'd2;
                wdata = '1;
            end else begin
                rw = 2'd0;
            end
            if (stalled) begin
                checks++;
                if (rdata !== held) begin
                    errors++;
                    $display("FAIL %s_stall got %h want %h",
                             name, rdata, held);
                end
            end
            stalled = 1'b0;
            if (done) begin
                done_n = n;
                err_s = err;
            end else begin
                if (busy) busy_n++;
                if (rvalid) rv_n++;
                if (rvalid && rready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s_beat got %h want none",
                                 name, rdata);
                    end else begin
                        want = exp_q.pop_front();
                        if (rdata !== want) begin
                            errors++;
                            $display("FAIL %s_beat got %h want %h",
                                     name, rdata, want);
                        end
                    end
                end else if (rvalid) begin
                    stalled = 1'b1;
                    held = rdata;
                end
                tick();
                n++;
            end
        end
        rw = 2'd0;
        checks++;
        if (done_n != exp_done) begin
            errors++;
            $display("FAIL %s_done_cycle got %0d want %0d",
                     name, done_n, exp_done);
        end
        checks++;
        if (busy_n != exp_busy) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d want %0d",
                     name, busy_n, exp_busy);
        end
        checks++;
        if (err_s !== exp_err) begin
            errors++;
            $display("FAIL %s_err got %b want %b", name, err_s, exp_err);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing got %0d want 0 beats left",
                     name, exp_q.size());
        end
        if (a >= AW'(DP) || l == '0) begin
            checks++;
            if (rv_n != 0) begin
                errors++;
                $display("FAIL %s_rvalid got %0d want 0", name, rv_n);
            end
        end
        tick();
        checks++;
        if ({done, err, busy, rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL %s_after got %b want 0000",
                     name, {done, err, busy, rvalid});
        end
        rready = 1'b1;
    endtask

    task automatic test_burst_wrap();
        run_burst("wrap", 8'd14, 8'd4, 16'hFFFF, -1, 5, 4, 1'b0);
    endtask

    task automatic test_burst_stall();
        run_burst("stall", 8'd0, 8'd3, 16'hFFF9, -1, 6, 5, 1'b0);
    endtask

    task automatic test_burst_reject();
        run_burst("reject", 8'd16, 8'd4, 16'hFFFF, -1, 1, 0, 1'b1);
        run_burst("len0", 8'd2, 8'd0, 16'hFFFF, -1, 1, 0, 1'b0);
    endtask

    task automatic test_write_during_burst();
        run_burst("wrdrop", 8'd0, 8'd6, 16'hFFFF, 2, 7, 6, 1'b0);
        rw = 2'd1;
        addr = 8'd3;
        tick();
        rw = 2'd0;
        checks++;
        if (rdata !== 8'h03 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL wrdrop_read got %h/%b want 03/1",
                     rdata, rvalid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        run_burst("b2b_a", 8'd15, 8'd18, 16'hFFFF, -1, 19, 18, 1'b0);
        run_burst("b2b_b", 8'd7, 8'd1, 16'hFFFF, -1, 2, 1, 1'b0);
    endtask

    task automatic test_reset_mid_burst();
        rw = 2'd3;
        addr = 8'd0;
        len = 8'd10;
        rready = 1'b1;
        tick();
        rw = 2'd0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DP; i++) mdl[i] = '0;
        checks++;
        if ({rvalid, busy, done} !== 3'b000) begin
            errors++;
            $display("FAIL midrst_flags got %b want 000",
                     {rvalid, busy, done});
        end
        rw = 2'd1;
        addr = 8'd5;
        tick();
        rw = 2'd0;
        checks++;
        if (rdata !== 8'h00 || rvalid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_read got %h/%b want 00/1",
                     rdata, rvalid);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done got %b want 0", done);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_burst_wrap();
        test_burst_stall();
        test_burst_reject();
        test_write_during_burst();
        test_back_to_back();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
